// File: rtl/simplex_pkg.sv
// Shared definitions for the simplex solver and its tableau loader.
//   calc_nrows / calc_ncols : tableau geometry, also used by the solver
//   FP_ONE / FP_ZERO        : IEEE-754 single-precision constants
//   fp_neg                  : sign flip that writes both zeros as +0
//   loader_state_t          : loader FSM states
package simplex_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  // Constraint rows: each equality becomes a +row and a -row.
  function automatic int calc_nrows(input int nrleqmax, input int nreqmax);
    return nrleqmax + 2 * nreqmax;
  endfunction

  // Columns: decision variables, one slack per constraint row, then RHS.
  function automatic int calc_ncols(input int ncoefmax, input int nrows);
    return ncoefmax + nrows + 1;
  endfunction

  // Negating a zero of either sign yields +0 so the solver never sees -0.
  function automatic logic [31:0] fp_neg(input logic [31:0] v);
    if (v[30:0] == 31'd0) return FP_ZERO;
    return {~v[31], v[30:0]};
  endfunction

endpackage

// File: rtl/simplex_row_buf.sv
// Holds the +row of the equality being loaded so the -row can be
// produced without re-reading the stream.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write index (coefficient index, or NCOEFMAX for RHS)
//   wr_data : word to store
//   rd_addr : read index
//   rd_data : combinational read data
module simplex_row_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simplex_tableau_loader.sv
// Converts a serial LP problem stream into the initial simplex tableau,
// writing one cell per cycle in row-major order.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   start_i, cfg_*_i     : load request and active problem dimensions
//   in_valid_i/in_data_i : stream words, accepted when in_ready_o is high
//   wr_en_o/row/col/data : registered tableau write port
//   busy_o               : load in progress
//   done_o, cfg_err_o    : completion / rejected-start pulses
module simplex_tableau_loader
  import simplex_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NCOEFMAX   = 2,
  parameter int  NREQMAX    = 1,
  parameter int  NRLEQMAX   = 1,
  localparam int NROWS      = calc_nrows(NRLEQMAX, NREQMAX),
  localparam int NCOLS      = calc_ncols(NCOEFMAX, NROWS),
  localparam int ROW_W      = $clog2(NROWS + 1),
  localparam int COL_W      = $clog2(NCOLS),
  localparam int NCOEF_W    = $clog2(NCOEFMAX + 1),
  localparam int NRLEQ_W    = $clog2(NRLEQMAX + 1),
  localparam int NREQ_W     = $clog2(NREQMAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [NCOEF_W-1:0]    cfg_ncoef_i,
  input  logic [NRLEQ_W-1:0]    cfg_nrleq_i,
  input  logic [NREQ_W-1:0]     cfg_nreq_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  wr_en_o,
  output logic [ROW_W-1:0]      wr_row_o,
  output logic [COL_W-1:0]      wr_col_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int          BUF_AW     = $clog2(NCOEFMAX + 1);
  localparam logic [31:0] L_NCOEFMAX = 32'(NCOEFMAX);
  localparam logic [31:0] L_NRLEQMAX = 32'(NRLEQMAX);
  localparam logic [31:0] L_NREQMAX  = 32'(NREQMAX);
  localparam logic [31:0] L_NROWS    = 32'(NROWS);
  localparam logic [31:0] L_RHS      = 32'(NCOLS - 1);

  loader_state_t         state, state_next;
  logic [ROW_W-1:0]      row, row_next;
  logic [COL_W-1:0]      col, col_next;
  logic [NCOEF_W-1:0]    ncoef, ncoef_next;
  logic [NRLEQ_W-1:0]    nrleq, nrleq_next;
  logic [NREQ_W-1:0]     nreq, nreq_next;

  logic                  cfg_bad, consume, buf_sel, advance;
  logic [DATA_WIDTH-1:0] cell_data, buf_rd;
  logic [BUF_AW-1:0]     buf_addr;
  logic [31:0]           r_x, c_x, eq_off;
  logic                  is_coef, is_rhs, is_slack;

  assign r_x      = 32'(row);
  assign c_x      = 32'(col);
  assign eq_off   = r_x - L_NRLEQMAX;
  assign is_coef  = c_x < 32'(ncoef);
  assign is_rhs   = c_x == L_RHS;
  assign is_slack = c_x == L_NCOEFMAX + r_x;
  assign buf_addr = is_rhs ? BUF_AW'(NCOEFMAX) : BUF_AW'(col);

  assign cfg_bad = (32'(cfg_ncoef_i) == 32'd0) || (32'(cfg_ncoef_i) > L_NCOEFMAX) ||
                   (32'(cfg_nrleq_i) > L_NRLEQMAX) || (32'(cfg_nreq_i) > L_NREQMAX);

  // Decode the cell at (row, col): whether it takes a stream word, whether
  // it feeds the equality buffer, and the value to write.
  always_comb begin
    consume   = 1'b0;
    buf_sel   = 1'b0;
    cell_data = FP_ZERO;
    if (r_x < L_NRLEQMAX) begin
      if (r_x < 32'(nrleq)) begin
        if (is_coef || is_rhs) begin
          consume   = 1'b1;
          cell_data = in_data_i;
        end else if (is_slack) begin
          cell_data = FP_ONE;
        end
      end
    end else if (r_x < L_NROWS) begin
      // eq_off[0] distinguishes the +row (even) from its negated twin.
      if ((eq_off >> 1) < 32'(nreq)) begin
        if (is_coef || is_rhs) begin
          if (!eq_off[0]) begin
            consume   = 1'b1;
            buf_sel   = 1'b1;
            cell_data = in_data_i;
          end else begin
            cell_data = fp_neg(buf_rd);
          end
        end else if (is_slack) begin
          cell_data = FP_ONE;
        end
      end
    end else begin
      if (is_coef) begin
        consume   = 1'b1;
        cell_data = fp_neg(in_data_i);
      end
    end
  end

  assign in_ready_o = (state == ST_FILL) && consume;
  assign advance    = (state == ST_FILL) && (!consume || in_valid_i);
  assign busy_o     = (state == ST_FILL);

  simplex_row_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (NCOEFMAX + 1),
    .ADDR_W    (BUF_AW)
  ) u_row_buf (
    .clk    (clk_i),
    .wr_en  (advance && buf_sel),
    .wr_addr(buf_addr),
    .wr_data(in_data_i),
    .rd_addr(buf_addr),
    .rd_data(buf_rd)
  );

  // Next-state logic: latch the config on an accepted start, then walk
  // the tableau row-major, moving only when the current cell completes.
  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    ncoef_next = ncoef;
    nrleq_next = nrleq;
    nreq_next  = nreq;
    case (state)
      ST_IDLE: begin
        if (start_i && !cfg_bad) begin
          state_next = ST_FILL;
          row_next   = '0;
          col_next   = '0;
          ncoef_next = cfg_ncoef_i;
          nrleq_next = cfg_nrleq_i;
          nreq_next  = cfg_nreq_i;
        end
      end
      ST_FILL: begin
        if (advance) begin
          if (32'(col) == L_RHS) begin
            col_next = '0;
            if (32'(row) == L_NROWS) state_next = ST_DONE;
            else                     row_next   = row + ROW_W'(1);
          end else begin
            col_next = col + COL_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        row_next   = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters and the registered write/status outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      ncoef     <= '0;
      nrleq     <= '0;
      nreq      <= '0;
      wr_en_o   <= 1'b0;
      wr_row_o  <= '0;
      wr_col_o  <= '0;
      wr_data_o <= '0;
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      state     <= state_next;
      row       <= row_next;
      col       <= col_next;
      ncoef     <= ncoef_next;
      nrleq     <= nrleq_next;
      nreq      <= nreq_next;
      wr_en_o   <= advance;
      if (advance) begin
        wr_row_o  <= row;
        wr_col_o  <= col;
        wr_data_o <= cell_data;
      end
      done_o    <= (state == ST_DONE);
      cfg_err_o <= (state == ST_IDLE) && start_i && cfg_bad;
    end
  end

endmodule

// File: tb/tb_simplex_tableau_loader.sv
// Self-checking bench for simplex_tableau_loader. Two instances are used:
// dut_a with NREQMAX=1 and dut_b with NREQMAX=2. Expected tableaux are built
// from the problem definition as a whole matrix and then flattened into the
// row-major write order the loader must follow.
module tb_simplex_tableau_loader;

  localparam int NCOEFMAX = 2;
  localparam int NRLEQMAX = 1;
  localparam int NROWS_A  = 3;
  localparam int NCOLS_A  = 6;
  localparam int NROWS_B  = 5;
  localparam int NCOLS_B  = 8;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] data;
  } cell_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  cfg_ncoef = '0;
  logic        cfg_nrleq = 1'b0;
  logic [1:0]  cfg_nreq = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        ready_a, wr_en_a, busy_a, done_a, err_a;
  logic [1:0]  wr_row_a;
  logic [2:0]  wr_col_a;
  logic [31:0] wr_data_a;
  logic        ready_b, wr_en_b, busy_b, done_b, err_b;
  logic [2:0]  wr_row_b;
  logic [2:0]  wr_col_b;
  logic [31:0] wr_data_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int valid_mode = 0;
  logic toggle = 1'b0;

  int writes[2], first_wr[2], last_wr[2], done_cnt[2], done_cyc[2];
  int err_cnt[2], err_cyc[2], busy_seen[2];

  cell_t       exp_a[$];
  cell_t       exp_b[$];
  logic [31:0] stream_q[$];
  logic [31:0] load_words[$];
  logic [31:0] model_tab [0:7][0:7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  simplex_tableau_loader #(
    .DATA_WIDTH(32), .NCOEFMAX(NCOEFMAX), .NREQMAX(1), .NRLEQMAX(NRLEQMAX)
  ) dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_a),
    .cfg_ncoef_i(cfg_ncoef), .cfg_nrleq_i(cfg_nrleq), .cfg_nreq_i(cfg_nreq[0:0]),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(ready_a),
    .wr_en_o(wr_en_a), .wr_row_o(wr_row_a), .wr_col_o(wr_col_a), .wr_data_o(wr_data_a),
    .busy_o(busy_a), .done_o(done_a), .cfg_err_o(err_a)
  );

  simplex_tableau_loader #(
    .DATA_WIDTH(32), .NCOEFMAX(NCOEFMAX), .NREQMAX(2), .NRLEQMAX(NRLEQMAX)
  ) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start_b),
    .cfg_ncoef_i(cfg_ncoef), .cfg_nrleq_i(cfg_nrleq), .cfg_nreq_i(cfg_nreq),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(ready_b),
    .wr_en_o(wr_en_b), .wr_row_o(wr_row_b), .wr_col_o(wr_col_b), .wr_data_o(wr_data_b),
    .busy_o(busy_b), .done_o(done_b), .cfg_err_o(err_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] negModel(input logic [31:0] v);
    if ((v & 32'h7FFF_FFFF) == 32'd0) return 32'd0;
    return v ^ 32'h8000_0000;
  endfunction

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Stream driver: presents the head of stream_q and retires it when the
  // loader is ready (ready is stable from this negedge to the next posedge).
  always begin
    logic want;
    @(negedge clk);
    if (!rstn) begin
      in_valid = 1'b0;
    end else begin
      case (valid_mode)
        0:       want = 1'b1;
        1:       want = toggle;
        default: want = ($urandom_range(0, 3) != 0);
      endcase
      toggle = ~toggle;
      if (stream_q.size() > 0 && want) begin
        in_valid = 1'b1;
        in_data  = stream_q[0];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && (ready_a || ready_b)) void'(stream_q.pop_front());
    end
  end

  // Compare processes: every write must match the next expected cell.
  always @(negedge clk) begin : cmp_a
    cell_t e;
    if (rstn) begin
      if (wr_en_a) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL a_unexpected_write actual=row %0d col %0d required=no write",
                   wr_row_a, wr_col_a);
        end else begin
          e = exp_a.pop_front();
          checkOutput("a_wr_row", 32'(wr_row_a), 32'(e.row));
          checkOutput("a_wr_col", 32'(wr_col_a), 32'(e.col));
          checkOutput("a_wr_data", wr_data_a, e.data);
        end
        if (writes[0] == 0) first_wr[0] = cyc;
        last_wr[0] = cyc;
        writes[0]++;
      end
      if (done_a) begin done_cnt[0]++; done_cyc[0] = cyc; end
      if (err_a)  begin err_cnt[0]++;  err_cyc[0]  = cyc; end
      if (busy_a) busy_seen[0] = 1;
    end
  end

  always @(negedge clk) begin : cmp_b
    cell_t e;
    if (rstn) begin
      if (wr_en_b) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL b_unexpected_write actual=row %0d col %0d required=no write",
                   wr_row_b, wr_col_b);
        end else begin
          e = exp_b.pop_front();
          checkOutput("b_wr_row", 32'(wr_row_b), 32'(e.row));
          checkOutput("b_wr_col", 32'(wr_col_b), 32'(e.col));
          checkOutput("b_wr_data", wr_data_b, e.data);
        end
        if (writes[1] == 0) first_wr[1] = cyc;
        last_wr[1] = cyc;
        writes[1]++;
      end
      if (done_b) begin done_cnt[1]++; done_cyc[1] = cyc; end
      if (err_b)  begin err_cnt[1]++;  err_cyc[1]  = cyc; end
      if (busy_b) busy_seen[1] = 1;
    end
  end

  // Reference model: build the whole tableau from load_words, then queue it
  // in row-major order.
  task automatic buildExpected(input int sel, input int ncoef, input int nrleq, input int nreq);
    int nrows = sel ? NROWS_B : NROWS_A;
    int ncols = sel ? NCOLS_B : NCOLS_A;
    int idx = 0;
    int p;
    logic [31:0] v;
    cell_t c;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) model_tab[r][k] = 32'd0;
    for (int i = 0; i < nrleq; i++) begin
      for (int j = 0; j <= ncoef; j++) begin
        model_tab[i][(j == ncoef) ? ncols - 1 : j] = load_words[idx];
        idx = idx + 1;
      end
      model_tab[i][NCOEFMAX + i] = ONE;
    end
    for (int k = 0; k < nreq; k++) begin
      p = NRLEQMAX + 2 * k;
      for (int j = 0; j <= ncoef; j++) begin
        v = load_words[idx];
        idx = idx + 1;
        model_tab[p][(j == ncoef) ? ncols - 1 : j]     = v;
        model_tab[p + 1][(j == ncoef) ? ncols - 1 : j] = negModel(v);
      end
      model_tab[p][NCOEFMAX + p]         = ONE;
      model_tab[p + 1][NCOEFMAX + p + 1] = ONE;
    end
    for (int j = 0; j < ncoef; j++) begin
      model_tab[nrows][j] = negModel(load_words[idx]);
      idx = idx + 1;
    end
    for (int r = 0; r <= nrows; r++)
      for (int k = 0; k < ncols; k++) begin
        c.row = r; c.col = k; c.data = model_tab[r][k];
        if (sel == 0) exp_a.push_back(c); else exp_b.push_back(c);
      end
  endtask

  task automatic clearTrack(input int sel);
    writes[sel] = 0; first_wr[sel] = 0; last_wr[sel] = 0;
    done_cnt[sel] = 0; done_cyc[sel] = 0;
    err_cnt[sel] = 0; err_cyc[sel] = 0; busy_seen[sel] = 0;
  endtask

  task automatic applyStimulus(input int sel, input int ncoef, input int nrleq, input int nreq,
                               input int vmode, input int extra, input int hold);
    buildExpected(sel, ncoef, nrleq, nreq);
    stream_q.delete();
    foreach (load_words[i]) stream_q.push_back(load_words[i]);
    for (int i = 0; i < extra; i++) stream_q.push_back(randWord());
    clearTrack(sel);
    valid_mode = vmode;
    @(negedge clk);
    cfg_ncoef = 2'(ncoef);
    cfg_nrleq = 1'(nrleq);
    cfg_nreq  = 2'(nreq);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    start_cyc = cyc;
    repeat (hold) @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finishLoad(input int sel, input int extra, input int vmode);
    int n = 0;
    int ncells = sel ? (NROWS_B + 1) * NCOLS_B : (NROWS_A + 1) * NCOLS_A;
    while (done_cnt[sel] == 0 && n < 3000) begin @(negedge clk); #1; n++; end
    repeat (2) begin @(negedge clk); #1; end
    checkOutput("done_pulses", 32'(done_cnt[sel]), 32'd1);
    checkOutput("write_count", 32'(writes[sel]), 32'(ncells));
    checkOutput("cells_not_written", 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
    checkOutput("extra_words_left", 32'(stream_q.size()), 32'(extra));
    checkOutput("busy_after_done", 32'(sel ? busy_b : busy_a), 32'd0);
    if (vmode == 0) begin
      checkOutput("first_write_cycle", 32'(first_wr[sel] - start_cyc), 32'd2);
      checkOutput("last_write_cycle", 32'(last_wr[sel] - start_cyc), 32'(ncells + 1));
      checkOutput("done_cycle", 32'(done_cyc[sel] - start_cyc), 32'(ncells + 2));
    end
    exp_a.delete();
    exp_b.delete();
    stream_q.delete();
  endtask

  task automatic badStart(input int sel, input int ncoef, input int nrleq, input int nreq);
    clearTrack(sel);
    @(negedge clk);
    cfg_ncoef = 2'(ncoef);
    cfg_nrleq = 1'(nrleq);
    cfg_nreq  = 2'(nreq);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (5) begin @(negedge clk); #1; end
    checkOutput("cfg_err_pulses", 32'(err_cnt[sel]), 32'd1);
    checkOutput("cfg_err_cycle", 32'(err_cyc[sel] - start_cyc), 32'd1);
    checkOutput("cfg_err_writes", 32'(writes[sel]), 32'd0);
    checkOutput("cfg_err_busy", 32'(busy_seen[sel]), 32'd0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("a_ctrl_in_reset", 32'({wr_en_a, busy_a, done_a, err_a, ready_a}), 32'd0);
    checkOutput("a_addr_in_reset", 32'({wr_row_a, wr_col_a}), 32'd0);
    checkOutput("a_data_in_reset", wr_data_a, 32'd0);
    checkOutput("b_ctrl_in_reset", 32'({wr_en_b, busy_b, done_b, err_b, ready_b}), 32'd0);
    checkOutput("b_addr_in_reset", 32'({wr_row_b, wr_col_b}), 32'd0);
    checkOutput("b_data_in_reset", wr_data_b, 32'd0);
  endtask

  task automatic nominalWords();
    load_words = '{32'h3F80_0000, 32'h4000_0000, 32'h4100_0000,
                   32'h4040_0000, 32'h4000_0000, 32'h4140_0000,
                   32'h4040_0000, 32'h40A0_0000};
  endtask

  initial begin
    int n;
    int sel, nc, nl, nq, nwords;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkResetOutputs();
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] nominal load, continuous valid");
    nominalWords();
    applyStimulus(0, 2, 1, 1, 0, 1, 1);
    checkOutput("model_r0c2_slack", model_tab[0][2], 32'h3F80_0000);
    checkOutput("model_r1c5_rhs", model_tab[1][5], 32'h4140_0000);
    checkOutput("model_r2c0_neg3", model_tab[2][0], 32'hC040_0000);
    checkOutput("model_r2c4_slack", model_tab[2][4], 32'h3F80_0000);
    checkOutput("model_r3c1_neg5", model_tab[3][1], 32'hC0A0_0000);
    checkOutput("model_r3c5_zero", model_tab[3][5], 32'h0);
    finishLoad(0, 1, 0);

    $display("[TB] nominal load, valid every other cycle, start held into FILL");
    nominalWords();
    applyStimulus(0, 2, 1, 1, 1, 0, 5);
    finishLoad(0, 0, 1);

    $display("[TB] NREQMAX=2 with one active equality");
    nominalWords();
    applyStimulus(1, 2, 1, 1, 0, 0, 1);
    checkOutput("model_b_r4c6_zero", model_tab[4][6], 32'h0);
    checkOutput("model_b_r5c1_neg5", model_tab[5][1], 32'hC0A0_0000);
    finishLoad(1, 0, 0);

    $display("[TB] zero handling");
    load_words = '{32'h3F80_0000, 32'h4000_0000, 32'h4100_0000,
                   32'h0000_0000, 32'h4000_0000, 32'h4140_0000,
                   32'h8000_0000, 32'h40A0_0000};
    applyStimulus(0, 2, 1, 1, 0, 0, 1);
    checkOutput("model_eq_zero_minus", model_tab[2][0], 32'h0);
    checkOutput("model_obj_negzero", model_tab[3][0], 32'h0);
    finishLoad(0, 0, 0);

    $display("[TB] rejected starts");
    badStart(0, 0, 1, 1);
    badStart(0, 3, 1, 1);
    badStart(1, 2, 1, 3);

    $display("[TB] reset during FILL");
    nominalWords();
    applyStimulus(0, 2, 1, 1, 0, 0, 1);
    n = 0;
    while (writes[0] < 10 && n < 200) begin @(negedge clk); #1; n++; end
    checkOutput("writes_before_reset", 32'(writes[0]), 32'd10);
    #1 rstn = 1'b0;
    #1 checkResetOutputs();
    exp_a.delete();
    stream_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    nominalWords();
    applyStimulus(0, 2, 1, 1, 0, 0, 1);
    finishLoad(0, 0, 0);

    $display("[TB] randomized loads");
    for (int t = 0; t < 10; t++) begin
      sel = t % 2;
      nc  = $urandom_range(1, 2);
      nl  = $urandom_range(0, 1);
      nq  = $urandom_range(0, sel ? 2 : 1);
      nwords = (nl + nq) * (nc + 1) + nc;
      load_words.delete();
      for (int i = 0; i < nwords; i++) load_words.push_back(randWord());
      n = $urandom_range(0, 2);
      applyStimulus(sel, nc, nl, nq, 2, n, 1);
      finishLoad(sel, n, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
